// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch predictor for the 5-stage RV32I pipeline.
//   The IF side does a combinational lookup of the fetch PC in a direct-mapped
//   BTB. Each entry holds a valid bit, a tag, a target and a 2-bit counter.
//   The EX side compares the ALU's resolved control flow against the
//   prediction that travelled down the pipe. It raises mispredict/redirect
//   combinationally and trains the table at the clock edge.
//
//   Parameters
//     BTB_ENTRIES      table depth (power of 2, >= 2)
//
//   Ports
//     i_clk            clock, rising edge
//     i_rst            asynchronous active-high reset
//     i_pc_f           fetch PC
//     o_pred_taken_f   predicted taken for i_pc_f
//     o_pred_target_f  predicted next fetch PC
//     i_valid_e        EX holds a real instruction (not stalled or flushed)
//     i_pc_e           EX instruction PC
//     i_is_branch_e    EX instruction is a conditional branch
//     i_is_jump_e      EX instruction is jal/jalr
//     i_br_taken_e     branch condition resolved true
//     i_target_e       resolved control-flow target
//     i_pred_taken_e   IF prediction carried to EX
//     i_pred_target_e  IF predicted target carried to EX
//     o_mispredict     flush IF/ID and redirect fetch
//     o_redirect_pc    correct next PC (meaningful when o_mispredict=1)
//
//   Optional build macro BP_STATS_EN adds two saturating 32-bit counters:
//     o_ctrl_cnt       resolved control-flow instructions in EX
//     o_mispred_cnt    cycles with o_mispredict asserted
// ----------------------------------------------------------------------------
module branch_predictor #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_f,
    output logic        o_pred_taken_f,
    output logic [31:0] o_pred_target_f,
    input  logic        i_valid_e,
    input  logic [31:0] i_pc_e,
    input  logic        i_is_branch_e,
    input  logic        i_is_jump_e,
    input  logic        i_br_taken_e,
    input  logic [31:0] i_target_e,
    input  logic        i_pred_taken_e,
    input  logic [31:0] i_pred_target_e,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] o_ctrl_cnt,
    output logic [31:0] o_mispred_cnt
`endif
);

    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = 32 - IDXW - 2;

    // Counter encoding: 00 strongly not-taken ... 11 strongly taken.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic            btb_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]     btb_target [BTB_ENTRIES];
    logic [1:0]      btb_ctr    [BTB_ENTRIES];

    // ---- IF stage: lookup ----
    logic [IDXW-1:0] idx_f;
    logic [TAGW-1:0] tag_f;
    logic            hit_f;

    assign idx_f = i_pc_f[IDXW+1:2];
    assign tag_f = i_pc_f[31:IDXW+2];
    assign hit_f = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);

    assign o_pred_taken_f  = ~i_rst & hit_f & btb_ctr[idx_f][1];
    assign o_pred_target_f = o_pred_taken_f ? btb_target[idx_f] : i_pc_f + 32'd4;

    // ---- EX stage: resolve and compare against the carried prediction ----
    logic [IDXW-1:0] idx_e;
    logic [TAGW-1:0] tag_e;
    logic            hit_e;
    logic            actual_taken_e;
    logic [31:0]     correct_pc_e;

    assign idx_e = i_pc_e[IDXW+1:2];
    assign tag_e = i_pc_e[31:IDXW+2];
    assign hit_e = btb_valid[idx_e] && (btb_tag[idx_e] == tag_e);

    assign actual_taken_e = i_is_jump_e | (i_is_branch_e & i_br_taken_e);
    assign correct_pc_e   = actual_taken_e ? i_target_e : i_pc_e + 32'd4;

    // A correct direction with a wrong target only matters when taken.
    assign o_mispredict  = i_valid_e & ~i_rst &
                           ((actual_taken_e != i_pred_taken_e) |
                            (actual_taken_e & (i_target_e != i_pred_target_e)));
    assign o_redirect_pc = correct_pc_e;

    // ---- EX stage: table training (visible to IF from the next cycle) ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= 32'd0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (i_valid_e) begin
            if (i_is_jump_e) begin
                btb_valid[idx_e]  <= 1'b1;
                btb_tag[idx_e]    <= tag_e;
                btb_target[idx_e] <= i_target_e;
                btb_ctr[idx_e]    <= 2'b11;
            end else if (i_is_branch_e) begin
                if (hit_e) begin
                    btb_ctr[idx_e] <= i_br_taken_e ? ctr_inc(btb_ctr[idx_e])
                                                   : ctr_dec(btb_ctr[idx_e]);
                    if (i_br_taken_e)
                        btb_target[idx_e] <= i_target_e;
                end else if (i_br_taken_e) begin
                    // Allocation evicts whatever aliased into this slot.
                    btb_valid[idx_e]  <= 1'b1;
                    btb_tag[idx_e]    <= tag_e;
                    btb_target[idx_e] <= i_target_e;
                    btb_ctr[idx_e]    <= 2'b10;
                end
            end else if (hit_e) begin
                // A non-control instruction matched: the entry is a stale alias.
                btb_valid[idx_e] <= 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ctrl_cnt    <= 32'd0;
            o_mispred_cnt <= 32'd0;
        end else begin
            if (i_valid_e & (i_is_branch_e | i_is_jump_e))
                o_ctrl_cnt <= sat_inc32(o_ctrl_cnt);
            if (o_mispredict)
                o_mispred_cnt <= sat_inc32(o_mispred_cnt);
        end
    end
`endif

endmodule
